// File: rtl/pong_pkg.sv
// Shared key codes and game-state encoding for the pong input path.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] KEY_W_PRESS     = 8'h00;
  localparam logic [7:0] KEY_S_PRESS     = 8'h01;
  localparam logic [7:0] KEY_UP_PRESS    = 8'h04;
  localparam logic [7:0] KEY_DN_PRESS    = 8'h05;
  localparam logic [7:0] KEY_ENTER_PRESS = 8'h10;
  localparam logic [7:0] KEY_SPACE_PRESS = 8'h11;
  localparam logic [7:0] KEY_W_REL       = 8'h80;
  localparam logic [7:0] KEY_S_REL       = 8'h81;
  localparam logic [7:0] KEY_UP_REL      = 8'h14;
  localparam logic [7:0] KEY_DN_REL      = 8'h15;
  localparam logic [7:0] KEY_ENTER_REL   = 8'h90;
  localparam logic [7:0] KEY_SPACE_REL   = 8'h91;

  typedef struct packed {
    logic w;
    logic s;
    logic up;
    logic dn;
  } keys_t;

endpackage

// File: rtl/pong_step_timer.sv
// Free-running step divider; counts only while enabled, otherwise parked at 0.
module pong_step_timer #(
  parameter int STEP_DIV = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/pong_input_scheduler.sv
// Turns key events into held-key flags, a game-state FSM and periodic paddle step pulses.
module pong_input_scheduler
  import pong_pkg::*;
#(
  parameter int STEP_DIV = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_code,
  input  logic       i_code_valid,
  input  logic       i_round_over,
  output logic       o_p1_up,
  output logic       o_p1_down,
  output logic       o_p2_up,
  output logic       o_p2_down,
  output logic [1:0] o_state,
  output logic       o_start
);
  state_e     state_q, state_d;
  keys_t      keys_q, keys_d;
  logic [3:0] pulse_q, pulse_d;
  logic       start_q, start_d;
  logic       enter_p, space_p, run_hold, tick;

  assign enter_p = i_code_valid && (i_code == KEY_ENTER_PRESS);
  assign space_p = i_code_valid && (i_code == KEY_SPACE_PRESS);

  always_comb begin
    keys_d = keys_q;
    if (i_code_valid) begin
      case (i_code)
        KEY_W_PRESS:  keys_d.w  = 1'b1;
        KEY_S_PRESS:  keys_d.s  = 1'b1;
        KEY_UP_PRESS: keys_d.up = 1'b1;
        KEY_DN_PRESS: keys_d.dn = 1'b1;
        KEY_W_REL:    keys_d.w  = 1'b0;
        KEY_S_REL:    keys_d.s  = 1'b0;
        KEY_UP_REL:   keys_d.up = 1'b0;
        KEY_DN_REL:   keys_d.dn = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      keys_q  <= '0;
      pulse_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      pulse_q <= pulse_d;
      start_q <= start_d;
    end
  end

  // round_over is checked first so it wins over a coincident Enter/Space
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enter_p) state_d = ST_RUN;
      ST_RUN:   if (i_round_over || enter_p) state_d = ST_IDLE;
                else if (space_p) state_d = ST_PAUSE;
      ST_PAUSE: if (i_round_over || enter_p) state_d = ST_IDLE;
                else if (space_p) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counting only while staying in RUN zeroes the counter on entry and kills
  // any tick that lands on the cycle the game leaves RUN.
  assign run_hold = (state_q == ST_RUN) && (state_d == ST_RUN);

  pong_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (run_hold),
    .o_tick (tick)
  );

  always_comb begin
    start_d = (state_q == ST_IDLE) && (state_d == ST_RUN);
    pulse_d = '0;
    if (tick) begin
      pulse_d[3] = keys_q.w  & ~keys_q.s;
      pulse_d[2] = keys_q.s  & ~keys_q.w;
      pulse_d[1] = keys_q.up & ~keys_q.dn;
      pulse_d[0] = keys_q.dn & ~keys_q.up;
    end
  end

  assign o_state   = state_q;
  assign o_start   = start_q;
  assign o_p1_up   = pulse_q[3];
  assign o_p1_down = pulse_q[2];
  assign o_p2_up   = pulse_q[1];
  assign o_p2_down = pulse_q[0];

endmodule

// File: tb/tb_pong_input_scheduler.sv
// Directed bench for pong_input_scheduler with STEP_DIV=4.
module tb_pong_input_scheduler;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_code;
  logic       i_code_valid;
  logic       i_round_over;
  logic       o_p1_up, o_p1_down, o_p2_up, o_p2_down, o_start;
  logic [1:0] o_state;
  logic [3:0] pul;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pong_input_scheduler #(.STEP_DIV(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_code       (i_code),
    .i_code_valid (i_code_valid),
    .i_round_over (i_round_over),
    .o_p1_up      (o_p1_up),
    .o_p1_down    (o_p1_down),
    .o_p2_up      (o_p2_up),
    .o_p2_down    (o_p2_down),
    .o_state      (o_state),
    .o_start      (o_start)
  );

  assign pul = {o_p1_up, o_p1_down, o_p2_up, o_p2_down};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    i_code = c;
    i_code_valid = 1'b1;
    step();
    i_code_valid = 1'b0;
    i_code = 8'hFF;
  endtask

  task automatic chk_run(input string tag, input logic [3:0] exp_pul);
    chk({tag, "_state"}, 8'(o_state), 8'd1);
    chk({tag, "_pul"}, 8'(pul), 8'(exp_pul));
  endtask

  initial begin
    i_rst = 1'b1; i_code = 8'hFF; i_code_valid = 1'b0; i_round_over = 1'b0;
    step(); step();
    chk("rst_state", 8'(o_state), 8'd0);
    chk("rst_start", 8'(o_start), 8'd0);
    chk("rst_pul", 8'(pul), 8'd0);
    i_rst = 1'b0;

    // IDLE: unknown code, release of a non-held key
    send(8'hFF); chk("idle_ff", 8'(o_state), 8'd0);
    send(8'h15); chk("idle_rel", 8'(o_state), 8'd0);

    // Enter -> RUN, single start pulse, W pressed twice, pulses at c4,c8,c12
    send(8'h10);
    chk("start_state", 8'(o_state), 8'd1);
    chk("start_pulse", 8'(o_start), 8'd1);
    chk("start_pul", 8'(pul), 8'd0);
    send(8'h00);
    chk("c1_start", 8'(o_start), 8'd0);
    chk_run("c1", 4'b0000);
    send(8'h00);
    chk_run("c2", 4'b0000);
    for (int n = 3; n <= 12; n++) begin
      step();
      chk("w_start", 8'(o_start), 8'd0);
      chk_run("w_hold", (n % 4 == 0) ? 4'b1000 : 4'b0000);
    end
    send(8'h80);
    chk_run("w_rel", 4'b0000);
    for (int n = 14; n <= 20; n++) begin
      step();
      chk_run("w_off", 4'b0000);
    end
    send(8'h10); chk("w_exit", 8'(o_state), 8'd0);

    // Up+Down opposed: no p2 steps; Down release resumes p2_up at next tick
    send(8'h04); send(8'h05);
    send(8'h10); chk("ud_start", 8'(o_start), 8'd1);
    for (int n = 1; n <= 20; n++) begin
      step();
      chk_run("ud_both", 4'b0000);
    end
    send(8'h15); chk_run("ud_c21", 4'b0000);
    step(); chk_run("ud_c22", 4'b0000);
    step(); chk_run("ud_c23", 4'b0000);
    step(); chk_run("ud_c24", 4'b0010);
    send(8'h10); chk("ud_exit", 8'(o_state), 8'd0);
    send(8'h14);

    // Pause with S held, resume: no start pulse, first p1_down 4 cycles later
    send(8'h01);
    send(8'h10);
    step();
    send(8'h11);
    chk("pause_state", 8'(o_state), 8'd2);
    chk("pause_pul", 8'(pul), 8'd0);
    for (int n = 0; n < 8; n++) begin
      step();
      chk("pause_hold_state", 8'(o_state), 8'd2);
      chk("pause_hold_pul", 8'(pul), 8'd0);
    end
    send(8'h91); chk("pause_spc_rel", 8'(o_state), 8'd2);
    send(8'h11);
    chk("resume_state", 8'(o_state), 8'd1);
    chk("resume_start", 8'(o_start), 8'd0);
    for (int n = 1; n <= 3; n++) begin
      step();
      chk_run("resume_wait", 4'b0000);
    end
    step(); chk_run("resume_c4", 4'b0100);

    // Unknown code in RUN, round_over beating Enter, round_over with a release
    send(8'hFF); chk_run("run_ff", 4'b0000);
    i_round_over = 1'b1; send(8'h10); i_round_over = 1'b0;
    chk("ro_enter_state", 8'(o_state), 8'd0);
    chk("ro_enter_start", 8'(o_start), 8'd0);
    chk("ro_enter_pul", 8'(pul), 8'd0);
    send(8'h10); chk("ro2_start", 8'(o_start), 8'd1);
    i_round_over = 1'b1; send(8'h81); i_round_over = 1'b0;
    chk("ro_rel_state", 8'(o_state), 8'd0);
    send(8'h10);
    for (int n = 1; n <= 8; n++) begin
      step();
      chk_run("s_cleared", 4'b0000);
    end
    send(8'h10);

    // Reset one cycle before a tick with W held; code during reset ignored
    send(8'h00);
    send(8'h10);
    step(); step();
    i_rst = 1'b1; step();
    chk("mid_rst_state", 8'(o_state), 8'd0);
    chk("mid_rst_pul", 8'(pul), 8'd0);
    chk("mid_rst_start", 8'(o_start), 8'd0);
    send(8'h00);
    send(8'h10);
    chk("rst_enter_state", 8'(o_state), 8'd0);
    chk("rst_enter_start", 8'(o_start), 8'd0);
    i_rst = 1'b0;
    step(); chk("post_rst_pul", 8'(pul), 8'd0);
    send(8'h10); chk("post_rst_start", 8'(o_start), 8'd1);
    for (int n = 1; n <= 4; n++) begin
      step();
      chk_run("post_rst_noW", 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_input_scheduler.md
PONG_INPUT_SCHEDULER -- requirements
Module: pong_input_scheduler

Interface
REQ-001 Parameter STEP_DIV, default 250000: clock cycles between paddle step opportunities; legal range 2..2^24.
REQ-002 i_clk  input  1  system clock; all logic on the rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_code  input  8  key event code from the PS/2 interpreter.
REQ-005 i_code_valid  input  1  one-cycle strobe; i_code is valid in that cycle only.
REQ-006 i_round_over  input  1  one-cycle strobe from game logic marking the end of a round.
REQ-007 o_p1_up, o_p1_down, o_p2_up, o_p2_down  output  1 each  one-cycle paddle step pulses.
REQ-008 o_state  output  2  game state: 2'd0 IDLE, 2'd1 RUN, 2'd2 PAUSE.
REQ-009 o_start  output  1  one-cycle pulse on each IDLE->RUN transition.

Function
REQ-010 Code table. Press codes: 8'h00 W, 8'h01 S, 8'h04 Up, 8'h05 Down, 8'h10 Enter, 8'h11 Space. Release codes: 8'h80 W, 8'h81 S, 8'h14 Up, 8'h15 Down, 8'h90 Enter, 8'h91 Space. All other codes, including 8'hFF, SHALL be ignored.
REQ-011 Four held flags (W, S, Up, Down) SHALL set on press and clear on release, in the cycle after i_code_valid, in every game state.
REQ-012 Enter and Space SHALL act on press codes only; their release codes SHALL have no effect.
REQ-013 FSM transitions: IDLE + Enter press -> RUN; RUN + Space press -> PAUSE; PAUSE + Space press -> RUN; RUN or PAUSE + i_round_over -> IDLE; RUN or PAUSE + Enter press -> IDLE; all other events leave the state unchanged.
REQ-014 o_start SHALL pulse in the same cycle in which o_state first reads RUN after leaving IDLE; the PAUSE->RUN transition SHALL NOT pulse o_start.
REQ-015 The step counter SHALL count 0..STEP_DIV-1 and wrap while in RUN, and SHALL be held at 0 in IDLE and PAUSE; its width is $clog2(STEP_DIV).
REQ-016 When the counter equals STEP_DIV-1 in RUN, a tick occurs; in the next cycle o_p1_up = W & ~S, o_p1_down = S & ~W, o_p2_up = Up & ~Down, o_p2_down = Down & ~Up, all sampled from the held flags at the tick cycle.
REQ-017 Opposing keys held together SHALL produce no step for that player.
REQ-018 After entering RUN, the first tick SHALL occur exactly STEP_DIV cycles after the first RUN cycle.
REQ-019 No step pulse SHALL be asserted in IDLE or PAUSE, including a tick that coincides with a transition out of RUN.
REQ-020 If i_round_over and i_code_valid arrive in the same cycle, i_round_over SHALL take priority for the state transition, and the held-flag update SHALL still be applied.
REQ-021 A press of an already-held key and a release of a non-held key SHALL be idempotent.

Reset
REQ-022 On i_rst the following SHALL take effect in the next cycle: state = IDLE, all held flags = 0, counter = 0, and all pulse outputs = 0.
REQ-023 A reset asserted mid-RUN SHALL suppress any pending step pulse and any o_start pulse.
REQ-024 i_code_valid received while i_rst is asserted SHALL be ignored.

Structure
REQ-025 Package pong_pkg SHALL hold the key code constants (REQ-010) and the game-state encoding (REQ-008), shared with ps2_interpreter consumers.
REQ-026 One sub-module, pong_step_timer, SHALL implement the STEP_DIV counter; its inputs are i_clk, i_rst, and enable (RUN), and its output is the tick.
REQ-027 All outputs SHALL be registered.
REQ-028 Target size for the implementation is 120-400 lines of RTL.

Verification (bench uses STEP_DIV=4)
REQ-029 Reset, then Enter (8'h10) -> o_start pulse for exactly 1 cycle, o_state=1, and no step pulses for the first 4 cycles.
REQ-030 In RUN, W press (8'h00) held for 12 cycles -> o_p1_up pulses exactly 3 times, 4 cycles apart; W release (8'h80) -> pulses stop.
REQ-031 In RUN, Up (8'h04) and Down (8'h05) both held -> o_p2_up = o_p2_down = 0 for 20 cycles; Down release (8'h15) -> o_p2_up resumes at the next tick.
REQ-032 In RUN, Space (8'h11) -> o_state=2 with no pulses while S stays held; Space again -> o_state=1, no o_start pulse, first o_p1_down pulse 4 cycles later.
REQ-033 In RUN, i_round_over in the same cycle as Enter press -> o_state=0 and no o_start pulse; unknown code 8'hFF in any state -> no change.
REQ-034 In RUN with W held, i_rst asserted one cycle before a tick -> no o_p1_up pulse, all outputs 0, and o_state=0.
